multicycle_control: RTL

//  Main sequencer for the multi-cycle RV32 core. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
//  It drives the PC, IR, register-file, memory and ALU-operand mux strobes around alu_control and the ALU.

---
 rtl/multicycle_control.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Main sequencer of the multi-cycle RV32 core: walks each instruction through
// FETCH/DECODE/EXEC/MEMACC/WB/BRANCH and drives the datapath strobes.
module multicycle_control #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [6:0] opcode_i,
    input  logic       mem_ready_i,
    input  logic       alu_cond_i,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       addr_sel_o,
    output logic       ir_write_o,
    output logic       pc_write_o,
    output logic       pc_src_o,
    output logic       reg_write_o,
    output logic [1:0] wb_sel_o,
    output logic [1:0] alu_src_a_o,
    output logic [1:0] alu_src_b_o,
    output logic       alu_dec_o,
    output logic       trap_o,
    output logic [2:0] state_o
);

    typedef enum logic [2:0] {
        FETCH  = 3'd0,
        DECODE = 3'd1,
        EXEC   = 3'd2,
        MEMACC = 3'd3,
        WB     = 3'd4,
        BRANCH = 3'd5,
        TRAP   = 3'd6
    } state_e;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

    state_e     state_q, state_d;
    logic [6:0] op_q, op_d;
    logic [7:0] wait_q, wait_d;
    logic       timeout;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= FETCH;
            op_q    <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        wait_d      = wait_q;
        mem_req_o   = 1'b0;
        mem_we_o    = 1'b0;
        addr_sel_o  = 1'b0;
        ir_write_o  = 1'b0;
        pc_write_o  = 1'b0;
        pc_src_o    = 1'b0;
        reg_write_o = 1'b0;
        wb_sel_o    = 2'b00;
        alu_src_a_o = 2'b00;
        alu_src_b_o = 2'b00;
        alu_dec_o   = 1'b0;
        trap_o      = 1'b0;
        timeout     = (wait_q == TIMEOUT_LAST);

        case (state_q)
            FETCH: begin
                mem_req_o   = 1'b1;
                alu_src_b_o = 2'b01;
                if (mem_ready_i) begin
                    ir_write_o = 1'b1;
                    pc_write_o = 1'b1;
                    state_d    = DECODE;
                end else if (timeout) begin
                    state_d = TRAP;
                end
            end
            DECODE: begin
                // Old PC + imm lands in the ALU-out register as the jump/branch target.
                op_d        = opcode_i;
                alu_src_a_o = 2'b10;
                alu_src_b_o = 2'b10;
                case (opcode_i)
                    OP_R, OP_I, OP_LOAD, OP_STORE, OP_JAL, OP_JALR: state_d = EXEC;
                    OP_BRANCH: state_d = BRANCH;
                    default:   state_d = TRAP;
                endcase
            end
            EXEC: begin
                case (op_q)
                    OP_R: begin
                        alu_src_a_o = 2'b01;
                        alu_dec_o   = 1'b1;
                        state_d     = WB;
                    end
                    OP_I: begin
                        alu_src_a_o = 2'b01;
                        alu_src_b_o = 2'b10;
                        alu_dec_o   = 1'b1;
                        state_d     = WB;
                    end
                    OP_LOAD, OP_STORE: begin
                        alu_src_a_o = 2'b01;
                        alu_src_b_o = 2'b10;
                        state_d     = MEMACC;
                    end
                    OP_JAL: begin
                        pc_write_o  = 1'b1;
                        pc_src_o    = 1'b1;
                        reg_write_o = 1'b1;
                        wb_sel_o    = 2'b10;
                        state_d     = FETCH;
                    end
                    OP_JALR: begin
                        alu_src_a_o = 2'b01;
                        alu_src_b_o = 2'b10;
                        pc_write_o  = 1'b1;
                        reg_write_o = 1'b1;
                        wb_sel_o    = 2'b10;
                        state_d     = FETCH;
                    end
                    default: state_d = TRAP;
                endcase
            end
            MEMACC: begin
                mem_req_o  = 1'b1;
                addr_sel_o = 1'b1;
                mem_we_o   = (op_q == OP_STORE);
                if (mem_ready_i) begin
                    state_d = (op_q == OP_LOAD) ? WB : FETCH;
                end else if (timeout) begin
                    state_d = TRAP;
                end
            end
            WB: begin
                reg_write_o = 1'b1;
                wb_sel_o    = (op_q == OP_LOAD) ? 2'b01 : 2'b00;
                state_d     = FETCH;
            end
            BRANCH: begin
                alu_src_a_o = 2'b01;
                alu_dec_o   = 1'b1;
                pc_write_o  = alu_cond_i;
                pc_src_o    = 1'b1;
                state_d     = FETCH;
            end
            TRAP: begin
                trap_o = 1'b1;
            end
            default: state_d = TRAP;
        endcase

        // The wait counter only measures stalls within one memory-wait state.
        if (state_d != state_q) begin
            wait_d = '0;
        end else if ((state_q == FETCH || state_q == MEMACC) && !mem_ready_i) begin
            wait_d = wait_q + 8'd1;
        end

        if (reset_i) begin
            mem_req_o   = 1'b0;
            mem_we_o    = 1'b0;
            addr_sel_o  = 1'b0;
            ir_write_o  = 1'b0;
            pc_write_o  = 1'b0;
            pc_src_o    = 1'b0;
            reg_write_o = 1'b0;
            wb_sel_o    = 2'b00;
            alu_src_a_o = 2'b00;
            alu_src_b_o = 2'b00;
            alu_dec_o   = 1'b0;
            trap_o      = 1'b0;
        end
    end

    assign state_o = state_q;

endmodule
